// File: rtl/io_channel_if.sv
// Bus-and-tag connection between the io_channel and a daisy-chain of control units.
// The channel uses the master modport; a control unit (or its model) uses slave.
interface io_channel_if;
    logic [7:0] bus_out;
    logic [7:0] bus_in;
    logic       operational_out;
    logic       hold_out;
    logic       select_out;
    logic       address_out;
    logic       command_out;
    logic       service_out;
    logic       select_in;
    logic       operational_in;
    logic       address_in;
    logic       status_in;
    logic       service_in;

    modport master (
        output bus_out, operational_out, hold_out, select_out,
               address_out, command_out, service_out,
        input  bus_in, select_in, operational_in, address_in,
               status_in, service_in
    );

    modport slave (
        input  bus_out, operational_out, hold_out, select_out,
               address_out, command_out, service_out,
        output bus_in, select_in, operational_in, address_in,
               status_in, service_in
    );
endinterface

// File: rtl/io_channel.sv
// Byte-serial bus-and-tag channel: selection, command, status, data transfer and ending status.
// Define IO_CHANNEL_TIMEOUT_EN to bound every wait state with an 8-bit timeout.
module io_channel (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  address,
    input  logic [7:0]  command,
    input  logic [7:0]  count,
    input  logic        start_strobe,
    input  logic [7:0]  write_data,
    output logic        write_data_req,
    output logic [7:0]  read_data,
    output logic        read_data_valid,
    output logic [7:0]  res_count,
    output logic [7:0]  status,
    output logic        done,
    output logic        no_cu,
    output logic        timeout,
    output logic [3:0]  state,
    io_channel_if.master bus
);

    typedef enum logic [3:0] {
        STATE_IDLE       = 4'd0,
        STATE_SEL        = 4'd1,
        STATE_CMD        = 4'd2,
        STATE_STATUS     = 4'd3,
        STATE_DATA       = 4'd4,
        STATE_STOP       = 4'd5,
        STATE_END_STATUS = 4'd6,
        STATE_RELEASE    = 4'd7
    } state_t;

    state_t     state_q;
    logic [7:0] cmd_q;
    logic [7:0] res_count_q;
    logic [7:0] status_q;
    logic [7:0] bus_out_q;
    logic [7:0] read_data_q;
    logic       op_q, hold_q, sel_q, addr_q, cmd_out_q, svc_q;
    logic       rdv_q, wreq_q, done_q, no_cu_q;
    logic       is_read, is_write;

    assign is_read  = (cmd_q == 8'h02);
    assign is_write = (cmd_q == 8'h01);

`ifdef IO_CHANNEL_TIMEOUT_EN
    state_t     prev_q;
    logic [7:0] tmo_q;
    logic       timeout_q;
    logic       wait_state;
    logic       tmo_hit;

    assign wait_state = (state_q != STATE_IDLE) && (state_q != STATE_RELEASE);
    assign tmo_hit    = wait_state && (tmo_q == 8'hFF);
    assign timeout    = timeout_q;

    // Counter restarts whenever the state differs from the previous cycle's state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= STATE_IDLE;
            tmo_q  <= '0;
        end else begin
            prev_q <= state_q;
            if (!wait_state || (state_q != prev_q)) tmo_q <= '0;
            else                                    tmo_q <= tmo_q + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= STATE_IDLE;
            cmd_q       <= '0;
            res_count_q <= '0;
            status_q    <= '0;
            bus_out_q   <= '0;
            read_data_q <= '0;
            op_q        <= 1'b0;
            hold_q      <= 1'b0;
            sel_q       <= 1'b0;
            addr_q      <= 1'b0;
            cmd_out_q   <= 1'b0;
            svc_q       <= 1'b0;
            rdv_q       <= 1'b0;
            wreq_q      <= 1'b0;
            done_q      <= 1'b0;
            no_cu_q     <= 1'b0;
`ifdef IO_CHANNEL_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            rdv_q  <= 1'b0;
            wreq_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                STATE_IDLE: begin
                    op_q <= 1'b1;
                    if (start_strobe) begin
                        cmd_q       <= command;
                        res_count_q <= count;
                        no_cu_q     <= 1'b0;
`ifdef IO_CHANNEL_TIMEOUT_EN
                        timeout_q   <= 1'b0;
`endif
                        bus_out_q   <= address;
                        hold_q      <= 1'b1;
                        sel_q       <= 1'b1;
                        addr_q      <= 1'b1;
                        state_q     <= STATE_SEL;
                    end
                end
                STATE_SEL: begin
                    if (bus.select_in) begin
                        no_cu_q <= 1'b1;
                        state_q <= STATE_RELEASE;
                    end else if (bus.address_in && bus.operational_in) begin
                        addr_q    <= 1'b0;
                        bus_out_q <= cmd_q;
                        cmd_out_q <= 1'b1;
                        state_q   <= STATE_CMD;
                    end
                end
                STATE_CMD: begin
                    if (!bus.address_in) begin
                        cmd_out_q <= 1'b0;
                        state_q   <= STATE_STATUS;
                    end
                end
                STATE_STATUS: begin
                    // Status is latched when accepted; the branch is taken once status_in drops.
                    if (!svc_q) begin
                        if (bus.status_in) begin
                            status_q <= bus.bus_in;
                            svc_q    <= 1'b1;
                        end
                    end else if (!bus.status_in) begin
                        svc_q   <= 1'b0;
                        state_q <= ((status_q & 8'h18) != 8'h00) ? STATE_RELEASE : STATE_DATA;
                    end
                end
                STATE_DATA: begin
                    if (svc_q) begin
                        if (!bus.service_in) svc_q <= 1'b0;
                    end else if (bus.status_in) begin
                        state_q <= STATE_END_STATUS;
                    end else if (bus.service_in) begin
                        if (res_count_q != 8'h00) begin
                            if (is_read) begin
                                read_data_q <= bus.bus_in;
                                rdv_q       <= 1'b1;
                            end
                            if (is_write) begin
                                bus_out_q <= write_data;
                                wreq_q    <= 1'b1;
                            end
                            svc_q       <= 1'b1;
                            res_count_q <= res_count_q - 8'd1;
                        end else begin
                            cmd_out_q <= 1'b1;
                            state_q   <= STATE_STOP;
                        end
                    end
                end
                STATE_STOP: begin
                    if (!bus.service_in) begin
                        cmd_out_q <= 1'b0;
                        state_q   <= STATE_END_STATUS;
                    end
                end
                STATE_END_STATUS: begin
                    if (!svc_q) begin
                        if (bus.status_in) begin
                            status_q <= bus.bus_in;
                            svc_q    <= 1'b1;
                        end
                    end else if (!bus.status_in) begin
                        svc_q   <= 1'b0;
                        state_q <= STATE_RELEASE;
                    end
                end
                STATE_RELEASE: begin
                    hold_q    <= 1'b0;
                    sel_q     <= 1'b0;
                    addr_q    <= 1'b0;
                    cmd_out_q <= 1'b0;
                    svc_q     <= 1'b0;
                    bus_out_q <= '0;
                    done_q    <= 1'b1;
                    state_q   <= STATE_IDLE;
                end
                default: state_q <= STATE_IDLE;
            endcase
`ifdef IO_CHANNEL_TIMEOUT_EN
            if (tmo_hit) begin
                timeout_q <= 1'b1;
                state_q   <= STATE_RELEASE;
            end
`endif
        end
    end

    assign bus.bus_out         = bus_out_q;
    assign bus.operational_out = op_q;
    assign bus.hold_out        = hold_q;
    assign bus.select_out      = sel_q;
    assign bus.address_out     = addr_q;
    assign bus.command_out     = cmd_out_q;
    assign bus.service_out     = svc_q;

    assign write_data_req  = wreq_q;
    assign read_data       = read_data_q;
    assign read_data_valid = rdv_q;
    assign res_count       = res_count_q;
    assign status          = status_q;
    assign done            = done_q;
    assign no_cu           = no_cu_q;
    assign state           = state_q;

endmodule

// File: tb/tb_io_channel.sv
// Scoreboard bench for io_channel: a control-unit model answers the bus-and-tag
// handshake while monitors compare read bytes, written bytes and end-of-operation results.
module tb_io_channel;

    logic       clk;
    logic       reset_n;
    logic [7:0] address, command, count, write_data;
    logic       start_strobe;
    logic       write_data_req, read_data_valid, done, no_cu, timeout;
    logic [7:0] read_data, res_count, status;
    logic [3:0] state;

    io_channel_if cu_if ();

    io_channel dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .address         (address),
        .command         (command),
        .count           (count),
        .start_strobe    (start_strobe),
        .write_data      (write_data),
        .write_data_req  (write_data_req),
        .read_data       (read_data),
        .read_data_valid (read_data_valid),
        .res_count       (res_count),
        .status          (status),
        .done            (done),
        .no_cu           (no_cu),
        .timeout         (timeout),
        .state           (state),
        .bus             (cu_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic [7:0] st;
        logic       nocu;
    } end_t;

    logic [7:0] exp_rd[$];
    logic [7:0] exp_wr[$];
    end_t       exp_end[$];

    int n_vec = 0;
    int n_err = 0;

    // Control-unit model configuration
    logic       term_en  = 1'b0;
    logic       cu_en    = 1'b0;
    logic [7:0] cu_addr  = 8'h00;
    logic [7:0] cu_init  = 8'h00;
    int         cu_bytes = 0;
    int         wr_idx   = 0;

    localparam int T_ADR = 0;
    localparam int T_CMD = 1;
    localparam int T_SVC = 2;

    assign cu_if.select_in = term_en ? cu_if.select_out : 1'b0;
    assign write_data      = 8'hA0 + 8'(wr_idx);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic tag(input int id);
        case (id)
            T_ADR:   return cu_if.address_out;
            T_CMD:   return cu_if.command_out;
            T_SVC:   return cu_if.service_out;
            default: return 1'b0;
        endcase
    endfunction

    task automatic cu_wait(input int id, input logic val, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!reset_n) return;
            if (tag(id) === val) begin
                ok = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        if (reset_n) chk("cu_wait_tag", 32'(id), 32'hFFFF);
    endtask

    task automatic cu_idle();
        cu_if.bus_in         = 8'h00;
        cu_if.operational_in = 1'b0;
        cu_if.address_in     = 1'b0;
        cu_if.status_in      = 1'b0;
        cu_if.service_in     = 1'b0;
    endtask

    task automatic cu_transaction();
        logic       ok;
        logic       stopped;
        logic       seen;
        logic [7:0] cmd;
        cu_if.bus_in         = cu_addr;
        cu_if.operational_in = 1'b1;
        cu_if.address_in     = 1'b1;
        cu_wait(T_CMD, 1'b1, ok); if (!ok) begin cu_idle(); return; end
        cmd = cu_if.bus_out;
        cu_if.address_in = 1'b0;
        cu_wait(T_CMD, 1'b0, ok); if (!ok) begin cu_idle(); return; end
        cu_if.bus_in    = cu_init;
        cu_if.status_in = 1'b1;
        cu_wait(T_SVC, 1'b1, ok); if (!ok) begin cu_idle(); return; end
        cu_if.status_in = 1'b0;
        cu_wait(T_SVC, 1'b0, ok); if (!ok) begin cu_idle(); return; end
        if ((cu_init & 8'h18) == 8'h00) begin
            stopped = 1'b0;
            for (int i = 0; i < cu_bytes && !stopped; i++) begin
                if (cmd != 8'h01) cu_if.bus_in = 8'h30 + 8'(i);
                cu_if.service_in = 1'b1;
                seen = 1'b0;
                for (int k = 0; k < 200 && !seen; k++) begin
                    if (!reset_n) begin cu_idle(); return; end
                    if (cu_if.service_out || cu_if.command_out) seen = 1'b1;
                    else begin @(posedge clk); #1; end
                end
                if (!seen) begin chk("cu_data_resp", 32'h0, 32'h1); cu_idle(); return; end
                if (cu_if.command_out) begin
                    stopped = 1'b1;
                    cu_if.service_in = 1'b0;
                    cu_wait(T_CMD, 1'b0, ok); if (!ok) begin cu_idle(); return; end
                end else begin
                    if (cmd == 8'h01) begin
                        if (exp_wr.size() == 0) chk("wr_unexpected", 32'(cu_if.bus_out), 32'h100);
                        else chk("wr_byte", 32'(cu_if.bus_out), 32'(exp_wr.pop_front()));
                    end
                    cu_if.service_in = 1'b0;
                    cu_wait(T_SVC, 1'b0, ok); if (!ok) begin cu_idle(); return; end
                end
            end
            cu_if.bus_in    = 8'h0C;
            cu_if.status_in = 1'b1;
            cu_wait(T_SVC, 1'b1, ok); if (!ok) begin cu_idle(); return; end
            cu_if.status_in = 1'b0;
            cu_wait(T_SVC, 1'b0, ok); if (!ok) begin cu_idle(); return; end
        end
        cu_idle();
    endtask

    initial begin
        cu_idle();
        forever begin
            @(posedge clk); #1;
            if (cu_en && reset_n && cu_if.address_out && cu_if.bus_out == cu_addr)
                cu_transaction();
        end
    end

    // Host side advances to the next write byte after each consumption.
    initial begin
        forever begin
            @(negedge clk);
            if (write_data_req) wr_idx++;
        end
    end

    // Output monitor
    always @(negedge clk) begin
        if (reset_n) begin
            if (read_data_valid) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", 32'(read_data), 32'h100);
                else chk("rd_byte", 32'(read_data), 32'(exp_rd.pop_front()));
            end
            if (done) begin
                if (exp_end.size() == 0) chk("done_unexpected", 32'h1, 32'h0);
                else begin
                    end_t e;
                    e = exp_end.pop_front();
                    chk("end_res_count", 32'(res_count), 32'(e.res));
                    chk("end_status", 32'(status), 32'(e.st));
                    chk("end_no_cu", 32'(no_cu), 32'(e.nocu));
                    chk("end_state_idle", 32'(state), 32'h0);
                end
            end
        end
    end

    task automatic run_txn(input logic [7:0] addr, input logic [7:0] cmd, input logic [7:0] cnt,
                           input logic en, input logic term, input logic [7:0] init_st,
                           input int bytes, input int limit, input logic stray,
                           input logic [7:0] e_res, input logic [7:0] e_st, input logic e_nocu);
        int   n;
        int   cycles;
        end_t e;
        cu_en    = en;
        term_en  = term;
        cu_addr  = addr;
        cu_init  = init_st;
        cu_bytes = bytes;
        wr_idx   = 0;
        n = (int'(cnt) < bytes) ? int'(cnt) : bytes;
        if (en && ((init_st & 8'h18) == 8'h00)) begin
            for (int i = 0; i < n; i++) begin
                if (cmd == 8'h02) exp_rd.push_back(8'h30 + 8'(i));
                if (cmd == 8'h01) exp_wr.push_back(8'hA0 + 8'(i));
            end
        end
        e.res = e_res; e.st = e_st; e.nocu = e_nocu;
        exp_end.push_back(e);
        @(negedge clk);
        address = addr; command = cmd; count = cnt; start_strobe = 1'b1;
        @(negedge clk);
        start_strobe = 1'b0;
        address = 8'h77; count = 8'h55;
        cycles = 1;
        while (!done && cycles < limit) begin
            @(negedge clk);
            cycles++;
            start_strobe = stray && (cycles == 8);
        end
        start_strobe = 1'b0;
        chk("idle_within_limit", 32'(done), 32'h1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; start_strobe = 1'b0;
        address = 8'h00; command = 8'h00; count = 8'h00;
        #3;
        chk("reset_tags", 32'({cu_if.operational_out, cu_if.hold_out, cu_if.select_out,
                               cu_if.address_out, cu_if.command_out, cu_if.service_out}), 32'h0);
        chk("reset_outputs", 32'({state, done, no_cu, res_count, status, read_data_valid,
                                  write_data_req, cu_if.bus_out}), 32'h0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("op_out_after_reset", 32'(cu_if.operational_out), 32'h1);

        //       addr   cmd    cnt    cu    term  init   bytes lim  stray res    st     nocu
        run_txn(8'h10, 8'h02, 8'd6,  1'b0, 1'b1, 8'h00, 0,   20,  1'b0, 8'd6,  8'h00, 1'b1);
        run_txn(8'h1A, 8'h02, 8'd6,  1'b1, 1'b0, 8'h10, 0,   30,  1'b0, 8'd6,  8'h10, 1'b0);
        run_txn(8'h1A, 8'h02, 8'd6,  1'b1, 1'b0, 8'h00, 16,  300, 1'b1, 8'd0,  8'h0C, 1'b0);
        run_txn(8'h1A, 8'h02, 8'd16, 1'b1, 1'b0, 8'h00, 6,   300, 1'b0, 8'd10, 8'h0C, 1'b0);
        run_txn(8'h1A, 8'h01, 8'd6,  1'b1, 1'b0, 8'h00, 16,  300, 1'b0, 8'd0,  8'h0C, 1'b0);
        run_txn(8'h1A, 8'h01, 8'd16, 1'b1, 1'b0, 8'h00, 6,   300, 1'b0, 8'd10, 8'h0C, 1'b0);
        run_txn(8'h1A, 8'h03, 8'd0,  1'b1, 1'b0, 8'h08, 0,   30,  1'b0, 8'd0,  8'h08, 1'b0);
        run_txn(8'h1A, 8'hFF, 8'd6,  1'b1, 1'b0, 8'h0A, 0,   30,  1'b0, 8'd6,  8'h0A, 1'b0);
        run_txn(8'h1A, 8'h02, 8'd0,  1'b1, 1'b0, 8'h00, 16,  100, 1'b0, 8'd0,  8'h0C, 1'b0);

        // Reset in the middle of a data phase
        cu_en = 1'b1; term_en = 1'b0; cu_addr = 8'h22; cu_init = 8'h00; cu_bytes = 16;
        @(negedge clk);
        address = 8'h22; command = 8'h04; count = 8'd3; start_strobe = 1'b1;
        @(negedge clk);
        start_strobe = 1'b0;
        for (int i = 0; i < 50 && state != 4'd4; i++) @(negedge clk);
        chk("reached_data_state", 32'(state), 32'h4);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midop_reset_tags", 32'({cu_if.operational_out, cu_if.hold_out, cu_if.select_out,
                                     cu_if.address_out, cu_if.command_out, cu_if.service_out}), 32'h0);
        chk("midop_reset_state", 32'(state), 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("op_out_after_midop", 32'(cu_if.operational_out), 32'h1);
        repeat (4) @(negedge clk);

        chk("queues_empty", 32'(exp_rd.size() + exp_wr.size() + exp_end.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
